// File: rtl/core_selftest_seq.sv
// On-chip regression sequencer: replays stored vectors through the lisp core
// (reset, RAM image load, start, wait, compare) and tallies pass/fail results.
`timescale 1ns/1ps
module core_selftest_seq #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned NUM_TESTS      = 4,
  parameter int unsigned MAX_WORDS      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned RST_CYCLES     = 3,
  parameter int unsigned SETTLE_CYCLES  = 3,
  localparam int unsigned STRIDE = 3 + 2 * MAX_WORDS,
  localparam int unsigned ROM_AW = $clog2(NUM_TESTS * STRIDE),
  localparam int unsigned CNT_W  = $clog2(NUM_TESTS + 1),
  localparam int unsigned IDX_W  = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  core_rst,
  output logic                  core_start,
  output logic [DATA_WIDTH-1:0] core_expr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  core_halt,
  input  logic                  core_error,
  input  logic [DATA_WIDTH-1:0] core_val,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      pass_count,
  output logic [CNT_W-1:0]      fail_count,
  output logic [IDX_W-1:0]      first_fail_idx,
  output logic [1:0]            first_fail_kind,
  output logic [DATA_WIDTH-1:0] first_fail_val
);

  localparam int unsigned LEN_W  = $clog2(MAX_WORDS + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PH_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 4);

  typedef enum logic [3:0] {
    S_IDLE, S_CRST, S_HDR, S_LOAD, S_START, S_WAIT, S_SETTLE, S_NEXT, S_DONE
  } state_t;

  state_t                r_state, w_state;
  logic [PH_W-1:0]       r_ph, w_ph;
  logic [TMO_W-1:0]      r_tmo, w_tmo;
  logic [IDX_W-1:0]      r_idx, w_idx;
  logic [ROM_AW-1:0]     r_base, w_base;
  logic [LEN_W-1:0]      r_len, w_len;
  logic [LEN_W-1:0]      r_pairs, w_pairs;
  logic                  r_half, w_half;
  logic [ADDR_WIDTH-1:0] r_waddr, w_waddr;
  logic [DATA_WIDTH-1:0] r_expected, w_expected;
  logic [1:0]            r_kind, w_kind;
  logic [DATA_WIDTH-1:0] r_cap, w_cap;
  logic [ROM_AW-1:0]     r_rom_addr, w_rom_addr;
  logic                  r_core_rst, w_core_rst;
  logic                  r_core_start, w_core_start;
  logic [DATA_WIDTH-1:0] r_core_expr, w_core_expr;
  logic                  r_mem_we, w_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic [CNT_W-1:0]      r_pass, w_pass;
  logic [CNT_W-1:0]      r_fail, w_fail;
  logic [IDX_W-1:0]      r_ff_idx, w_ff_idx;
  logic [1:0]            r_ff_kind, w_ff_kind;
  logic [DATA_WIDTH-1:0] r_ff_val, w_ff_val;
  logic [LEN_W-1:0]      w_len_in;
  logic [LEN_W-1:0]      w_pairs_inc;

  // Next-state and next-output logic
  always_comb begin
    w_state      = r_state;
    w_ph         = r_ph;
    w_tmo        = r_tmo;
    w_idx        = r_idx;
    w_base       = r_base;
    w_len        = r_len;
    w_pairs      = r_pairs;
    w_half       = r_half;
    w_waddr      = r_waddr;
    w_expected   = r_expected;
    w_kind       = r_kind;
    w_cap        = r_cap;
    w_rom_addr   = r_rom_addr;
    w_core_rst   = 1'b0;
    w_core_start = 1'b0;
    w_core_expr  = r_core_expr;
    w_mem_we     = 1'b0;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_busy       = r_busy;
    w_done       = r_done;
    w_pass       = r_pass;
    w_fail       = r_fail;
    w_ff_idx     = r_ff_idx;
    w_ff_kind    = r_ff_kind;
    w_ff_val     = r_ff_val;
    w_len_in     = (rom_data > DATA_WIDTH'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : LEN_W'(rom_data);
    w_pairs_inc  = r_pairs + LEN_W'(1);

    case (r_state)
      S_IDLE, S_DONE: begin
        if (run) begin
          w_pass     = '0;
          w_fail     = '0;
          w_ff_idx   = '0;
          w_ff_kind  = '0;
          w_ff_val   = '0;
          w_idx      = '0;
          w_base     = '0;
          w_ph       = '0;
          w_busy     = 1'b1;
          w_done     = 1'b0;
          w_core_rst = 1'b1;
          w_state    = S_CRST;
        end
      end
      S_CRST: begin
        // core_rst already high on entry; one trailing low cycle before HDR
        w_ph       = r_ph + PH_W'(1);
        w_core_rst = (r_ph < PH_W'(RST_CYCLES - 1));
        if (r_ph == PH_W'(RST_CYCLES)) begin
          w_ph       = '0;
          w_rom_addr = r_base;
          w_state    = S_HDR;
        end
      end
      S_HDR: begin
        w_ph       = r_ph + PH_W'(1);
        w_rom_addr = r_rom_addr + ROM_AW'(1);
        if (r_ph == PH_W'(1)) w_core_expr = rom_data;
        if (r_ph == PH_W'(2)) w_expected = rom_data;
        if (r_ph == PH_W'(3)) begin
          w_len   = w_len_in;
          w_pairs = '0;
          w_half  = 1'b1;
          w_state = (w_len_in == '0) ? S_START : S_LOAD;
        end
      end
      S_LOAD: begin
        // rom_data alternates address word / data word; write on the data word
        w_rom_addr = r_rom_addr + ROM_AW'(1);
        if (r_half) begin
          w_waddr = rom_data[ADDR_WIDTH-1:0];
          w_half  = 1'b0;
        end else begin
          w_mem_we    = 1'b1;
          w_mem_addr  = r_waddr;
          w_mem_wdata = rom_data;
          w_pairs     = w_pairs_inc;
          w_half      = 1'b1;
          if (w_pairs_inc == r_len) w_state = S_START;
        end
      end
      S_START: begin
        w_core_start = 1'b1;
        w_tmo        = '0;
        w_kind       = 2'd0;
        w_state      = S_WAIT;
      end
      S_WAIT: begin
        w_tmo = r_tmo + TMO_W'(1);
        if (core_error) begin
          w_kind  = 2'd2;
          w_cap   = core_val;
          w_state = S_NEXT;
        end else if (core_halt) begin
          w_ph    = '0;
          w_state = S_SETTLE;
        end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          w_kind  = 2'd3;
          w_cap   = core_val;
          w_state = S_NEXT;
        end
      end
      S_SETTLE: begin
        w_ph = r_ph + PH_W'(1);
        if (r_ph == PH_W'(SETTLE_CYCLES - 1)) begin
          w_cap   = core_val;
          w_kind  = (core_val == r_expected) ? 2'd0 : 2'd1;
          w_state = S_NEXT;
        end
      end
      S_NEXT: begin
        if (r_kind == 2'd0) begin
          w_pass = r_pass + CNT_W'(1);
        end else begin
          w_fail = r_fail + CNT_W'(1);
          if (r_fail == '0) begin
            w_ff_idx  = r_idx;
            w_ff_kind = r_kind;
            w_ff_val  = r_cap;
          end
        end
        if (r_idx == IDX_W'(NUM_TESTS - 1)) begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_DONE;
        end else begin
          w_idx      = r_idx + IDX_W'(1);
          w_base     = r_base + ROM_AW'(STRIDE);
          w_ph       = '0;
          w_core_rst = 1'b1;
          w_state    = S_CRST;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_ph         <= '0;
      r_tmo        <= '0;
      r_idx        <= '0;
      r_base       <= '0;
      r_len        <= '0;
      r_pairs      <= '0;
      r_half       <= 1'b0;
      r_waddr      <= '0;
      r_expected   <= '0;
      r_kind       <= '0;
      r_cap        <= '0;
      r_rom_addr   <= '0;
      r_core_rst   <= 1'b0;
      r_core_start <= 1'b0;
      r_core_expr  <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= '0;
      r_fail       <= '0;
      r_ff_idx     <= '0;
      r_ff_kind    <= '0;
      r_ff_val     <= '0;
    end else begin
      r_state      <= w_state;
      r_ph         <= w_ph;
      r_tmo        <= w_tmo;
      r_idx        <= w_idx;
      r_base       <= w_base;
      r_len        <= w_len;
      r_pairs      <= w_pairs;
      r_half       <= w_half;
      r_waddr      <= w_waddr;
      r_expected   <= w_expected;
      r_kind       <= w_kind;
      r_cap        <= w_cap;
      r_rom_addr   <= w_rom_addr;
      r_core_rst   <= w_core_rst;
      r_core_start <= w_core_start;
      r_core_expr  <= w_core_expr;
      r_mem_we     <= w_mem_we;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_pass       <= w_pass;
      r_fail       <= w_fail;
      r_ff_idx     <= w_ff_idx;
      r_ff_kind    <= w_ff_kind;
      r_ff_val     <= w_ff_val;
    end
  end

  assign rom_addr        = r_rom_addr;
  assign core_rst        = r_core_rst;
  assign core_start      = r_core_start;
  assign core_expr       = r_core_expr;
  assign mem_we          = r_mem_we;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass_count      = r_pass;
  assign fail_count      = r_fail;
  assign first_fail_idx  = r_ff_idx;
  assign first_fail_kind = r_ff_kind;
  assign first_fail_val  = r_ff_val;

endmodule

// File: tb/tb_core_selftest_seq.sv
// Directed bench for core_selftest_seq: ROM and a tiny core model with
// per-vector behaviour (halt with RAM value, never halt, halt+error).
`timescale 1ns/1ps
module tb_core_selftest_seq;

  localparam int unsigned DW     = 16;
  localparam int unsigned AW     = 10;
  localparam int unsigned NT     = 3;
  localparam int unsigned MW     = 16;
  localparam int unsigned STRIDE = 3 + 2 * MW;
  localparam int unsigned RAW    = $clog2(NT * STRIDE);
  localparam logic [DW-1:0] TYPE_NUMBER = 16'h0001;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic [RAW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic          core_rst, core_start, mem_we, busy, done;
  logic [DW-1:0] core_expr, mem_wdata, first_fail_val;
  logic [AW-1:0] mem_addr;
  logic [1:0]    pass_count, fail_count, first_fail_idx, first_fail_kind;
  logic          m_halt = 1'b0;
  logic          m_err  = 1'b0;
  logic [DW-1:0] m_val  = '0;

  core_selftest_seq #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TESTS(NT), .MAX_WORDS(MW),
    .TIMEOUT_CYCLES(64), .RST_CYCLES(3), .SETTLE_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .core_rst(core_rst), .core_start(core_start), .core_expr(core_expr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_halt(m_halt), .core_error(m_err), .core_val(m_val),
    .busy(busy), .done(done),
    .pass_count(pass_count), .fail_count(fail_count),
    .first_fail_idx(first_fail_idx), .first_fail_kind(first_fail_kind),
    .first_fail_val(first_fail_val)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom [0:(1<<RAW)-1];
  logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};
  logic [1:0]    tv_mode [0:NT-1];
  logic          m_run  = 1'b0;
  int            m_cd   = 0;
  logic [1:0]    m_mode = 2'd0;
  int            m_vec  = 0;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // Core model: mode 0 halts with ram[expr], 1 never halts, 2 halt+error together
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (run && !busy) m_vec <= 0;
    if (core_rst) begin
      m_halt <= 1'b0; m_err <= 1'b0; m_val <= '0; m_run <= 1'b0;
    end else if (core_start) begin
      m_run  <= 1'b1;
      m_cd   <= 5;
      m_mode <= (m_vec < NT) ? tv_mode[m_vec] : 2'd1;
      m_vec  <= m_vec + 1;
    end else if (m_run) begin
      if (m_cd == 0) begin
        m_run <= 1'b0;
        if (m_mode == 2'd0) begin
          m_halt <= 1'b1;
          m_val  <= ram[core_expr[AW-1:0]];
        end else if (m_mode == 2'd2) begin
          m_halt <= 1'b1;
          m_err  <= 1'b1;
        end
      end else begin
        m_cd <= m_cd - 1;
      end
    end
  end

  int            cyc = 0;
  int            rst_hi = 0;
  int            ovl = 0;
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  int            st_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (core_start) st_q.push_back(cyc);
    if (core_rst) rst_hi++;
    if (int'(mem_we) + int'(core_start) + int'(core_rst) > 1) ovl++;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < (1 << RAW); i++) rom[i] = '0;
    for (int i = 0; i < NT; i++) tv_mode[i] = 2'd0;
  endtask

  task automatic set_vec(input int v, input logic [DW-1:0] e, input logic [DW-1:0] x,
                         input logic [DW-1:0] l);
    rom[v*STRIDE+0] = e;
    rom[v*STRIDE+1] = x;
    rom[v*STRIDE+2] = l;
  endtask

  task automatic set_pair(input int v, input int k, input logic [DW-1:0] a, input logic [DW-1:0] d);
    rom[v*STRIDE+3+2*k] = a;
    rom[v*STRIDE+4+2*k] = d;
  endtask

  task automatic load_basic();
    clear_rom();
    set_vec(0, 16'h0001, 16'h2A2A, 16'd2);
    set_pair(0, 0, 16'h0000, TYPE_NUMBER);
    set_pair(0, 1, 16'h0001, 16'h2A2A);
    set_vec(1, 16'h0005, 16'h00BE, 16'd1);
    set_pair(1, 0, 16'h0005, 16'h00BE);
    set_vec(2, 16'h0007, 16'h0000, 16'd0);
  endtask

  task automatic pulse_run();
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", 32'(done), 1);
  endtask

  int s, ss, r0, w, n, gap;

  initial begin
    load_basic();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_core_rst", 32'(core_rst), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_counts", {pass_count, fail_count, first_fail_kind}, 0);
    rst = 1'b1;
    @(negedge clk);

    // A: three passing vectors, first is the TYPE_NUMBER image
    s = wr_addr_q.size(); ss = st_q.size(); r0 = rst_hi;
    pulse_run();
    wait_done();
    chk("a_writes", 32'(wr_addr_q.size() - s), 3);
    chk("a_w0_addr", 32'(wr_addr_q[s]), 0);
    chk("a_w0_data", 32'(wr_data_q[s]), 32'(TYPE_NUMBER));
    chk("a_w1_addr", 32'(wr_addr_q[s+1]), 1);
    chk("a_w1_data", 32'(wr_data_q[s+1]), 32'h2A2A);
    chk("a_w2_addr", 32'(wr_addr_q[s+2]), 5);
    chk("a_starts", 32'(st_q.size() - ss), 3);
    chk("a_rst_cycles", 32'(rst_hi - r0), 9);
    chk("a_pass", 32'(pass_count), 3);
    chk("a_fail", 32'(fail_count), 0);
    chk("a_kind", 32'(first_fail_kind), 0);
    chk("a_busy", 32'(busy), 0);

    // B: vector 1 expects 1234 but the core returns 2A2A
    clear_rom();
    set_vec(0, 16'h0001, 16'h2A2A, 16'd2);
    set_pair(0, 0, 16'h0000, TYPE_NUMBER);
    set_pair(0, 1, 16'h0001, 16'h2A2A);
    set_vec(1, 16'h0001, 16'h1234, 16'd1);
    set_pair(1, 0, 16'h0001, 16'h2A2A);
    set_vec(2, 16'h0005, 16'h00BE, 16'd1);
    set_pair(2, 0, 16'h0005, 16'h00BE);
    pulse_run();
    wait_done();
    chk("b_pass", 32'(pass_count), 2);
    chk("b_fail", 32'(fail_count), 1);
    chk("b_idx", 32'(first_fail_idx), 1);
    chk("b_kind", 32'(first_fail_kind), 1);
    chk("b_val", 32'(first_fail_val), 32'h2A2A);

    // C: vector 1 never halts
    load_basic();
    tv_mode[1] = 2'd1;
    ss = st_q.size();
    pulse_run();
    wait_done();
    chk("c_pass", 32'(pass_count), 2);
    chk("c_fail", 32'(fail_count), 1);
    chk("c_idx", 32'(first_fail_idx), 1);
    chk("c_kind", 32'(first_fail_kind), 3);
    chk("c_val", 32'(first_fail_val), 0);
    chk("c_starts", 32'(st_q.size() - ss), 3);
    gap = st_q[ss+2] - st_q[ss+1];
    chk("c_timeout_gap", 32'(gap >= 64 && gap <= 64 + 3 + 40), 1);

    // D: halt and error together on vector 0; run pulsed mid-sequence
    load_basic();
    tv_mode[0] = 2'd2;
    ss = st_q.size();
    pulse_run();
    repeat (20) @(negedge clk);
    chk("d_busy_at_run", 32'(busy), 1);
    pulse_run();
    wait_done();
    chk("d_pass", 32'(pass_count), 2);
    chk("d_fail", 32'(fail_count), 1);
    chk("d_idx", 32'(first_fail_idx), 0);
    chk("d_kind", 32'(first_fail_kind), 2);
    chk("d_val", 32'(first_fail_val), 0);
    chk("d_starts", 32'(st_q.size() - ss), 3);
    repeat (5) @(negedge clk);
    chk("d_done_held", {30'd0, done, busy}, 32'h2);

    // E: L=40 clamped to 16; reset asserted in the middle of a LOAD write
    clear_rom();
    set_vec(0, 16'd115, 16'hA00F, 16'd40);
    for (int k = 0; k < 16; k++) set_pair(0, k, 16'(100 + k), 16'(16'hA000 + k));
    set_vec(1, 16'h0005, 16'h00BE, 16'd1);
    set_pair(1, 0, 16'h0005, 16'h00BE);
    set_vec(2, 16'h0007, 16'h0000, 16'd0);
    s = wr_addr_q.size();
    pulse_run();
    n = 0;
    while (wr_addr_q.size() < s + 3 && n < 500) begin @(negedge clk); n++; end
    n = 0;
    while (!mem_we && n < 10) begin @(negedge clk); n++; end
    chk("e_we_before_rst", 32'(mem_we), 1);
    #2 rst = 1'b0;
    #1;
    chk("e_rst_mem_we", 32'(mem_we), 0);
    chk("e_rst_ctl", {busy, done, core_rst, core_start}, 0);
    chk("e_rst_rom_addr", 32'(rom_addr), 0);
    chk("e_rst_expr", 32'(core_expr), 0);
    chk("e_rst_mem_addr", 32'(mem_addr), 0);
    w = wr_addr_q.size();
    repeat (5) @(negedge clk);
    chk("e_no_writes_in_rst", 32'(wr_addr_q.size() - w), 0);
    rst = 1'b1;
    @(negedge clk);
    s = wr_addr_q.size();
    pulse_run();
    wait_done();
    chk("e_writes", 32'(wr_addr_q.size() - s), 17);
    chk("e_last_addr", 32'(wr_addr_q[s+15]), 115);
    chk("e_last_data", 32'(wr_data_q[s+15]), 32'hA00F);
    chk("e_next_vec_addr", 32'(wr_addr_q[s+16]), 5);
    chk("e_pass", 32'(pass_count), 3);
    chk("e_fail", 32'(fail_count), 0);
    chk("overlap", 32'(ovl), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/core_selftest_seq.md
Name: core_selftest_seq

Overview:
- On-chip regression sequencer for the lisp core; replaces the simulation-only load/start/wait/check flow with synthesizable hardware.
- Runs NUM_TESTS vectors from a read-only vector store. For each vector it:
  - resets the core;
  - writes a sparse memory image into core RAM;
  - drives the expression value and pulses start;
  - waits for Halt/Error or a timeout;
  - compares the core's val register against the expected value.
- Sits beside core; in self-test builds it muxes onto the switch, start, core-reset and RAM write paths.

Parameters:
- DATA_WIDTH, 16, core data word width.
- ADDR_WIDTH, 10, core RAM address width (1024 words).
- NUM_TESTS, 4, number of vectors in the store.
- MAX_WORDS, 16, maximum (addr, data) pairs per vector image.
- TIMEOUT_CYCLES, 4096, cycles allowed in WAIT before declaring a timeout.
- RST_CYCLES, 3, cycles core_rst is held high per vector.
- SETTLE_CYCLES, 3, cycles between seeing halt and sampling core_val.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- run  in  1  single-cycle start request.
- rom_addr  out  clog2(NUM_TESTS*(3+2*MAX_WORDS))  vector store address.
- rom_data  in  DATA_WIDTH  vector store data; valid 1 cycle after rom_addr.
- core_rst  out  1  active-high reset to core.
- core_start  out  1  start pulse to core.
- core_expr  out  DATA_WIDTH  value presented on core switches.
- mem_we  out  1  core RAM write strobe.
- mem_addr  out  ADDR_WIDTH  core RAM write address.
- mem_wdata  out  DATA_WIDTH  core RAM write data.
- core_halt  in  1  core state == Halt.
- core_error  in  1  core state == Error.
- core_val  in  DATA_WIDTH  core val register.
- busy  out  1  sequence in progress.
- done  out  1  sequence complete; held until next run.
- pass_count  out  clog2(NUM_TESTS+1)  vectors passed.
- fail_count  out  clog2(NUM_TESTS+1)  vectors failed.
- first_fail_idx  out  clog2(NUM_TESTS)  index of first failing vector.
- first_fail_kind  out  2  first failure cause: 0 none, 1 mismatch, 2 core error, 3 timeout.
- first_fail_val  out  DATA_WIDTH  core_val captured at first failure.

Behaviour:
- Vector layout, stride S = 3+2*MAX_WORDS, base = idx*S:
  - word 0: expr value.
  - word 1: expected val.
  - word 2: pair count L.
  - words 3..3+2L-1: addr/data pairs. Addr uses the low ADDR_WIDTH bits.
  - L > MAX_WORDS is clamped to MAX_WORDS. L = 0 is legal (no writes).
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - All outputs 0, including core_rst, counters, first_fail_* and done.
  - Reset mid-sequence aborts immediately; no further RAM writes are issued.
- States:
  - IDLE: on run, clear counters and first_fail_*, set idx = 0, busy = 1, done = 0, go to CORE_RST.
  - CORE_RST: core_rst = 1 for exactly RST_CYCLES cycles, then 1 cycle with core_rst = 0, then HDR.
  - HDR: issue rom_addr base+0, +1, +2 on consecutive cycles. Latch expr, expected and L as data returns.
    - core_expr is driven from the latched expr from this point until the next vector's HDR.
  - LOAD: stream pairs. Data arrives 1 cycle after address, so the pipeline gives one write per 2 cycles.
    - mem_we is high for 1 cycle per pair, with mem_addr/mem_wdata valid in that cycle.
    - Go to START after L writes.
  - START: core_start = 1 for exactly one cycle. Clear the timeout counter. Go to WAIT.
  - WAIT (checked in this priority order):
    - core_error seen: the vector fails, kind 2. Error wins if core_halt is also high in the same cycle.
    - core_halt seen: go to SETTLE.
    - timeout counter reaches TIMEOUT_CYCLES: the vector fails, kind 3.
  - SETTLE: wait SETTLE_CYCLES, then sample core_val.
    - core_val == expected: pass_count increments.
    - otherwise: the vector fails, kind 1.
  - NEXT:
    - On a failure, fail_count increments. first_fail_* is written only when fail_count was 0 beforehand.
    - If idx == NUM_TESTS-1, go to DONE; otherwise idx increments and go to CORE_RST.
  - DONE: busy = 0, done = 1. run restarts from IDLE semantics (counters cleared).
- run is ignored while busy.
- Invariant: pass_count + fail_count == number of completed vectors; equals NUM_TESTS at done.
- mem_we, core_start and core_rst are never high in the same cycle.

Test Plan:
- NUM_TESTS=1; vector {expr 0001, expected 2A2A, L=2, (0,{0,TYPE_NUMBER}), (1,2A2A)}; run → exactly two mem_we pulses (addr 0, then addr 1), one core_start pulse, then done=1, pass_count=1, fail_count=0, first_fail_kind=0.
- NUM_TESTS=3; vector 1 expected 1234 but core_val=2A2A → pass_count=2, fail_count=1, first_fail_idx=1, first_fail_kind=1, first_fail_val=2A2A.
- Core never halts (model holds halt/error low), TIMEOUT_CYCLES=64 → fail kind 3; done asserts within 64+RST_CYCLES+overhead cycles of that vector's start.
- core_halt and core_error asserted in the same cycle → kind 2; run pulsed during busy → no effect on the counters or on the sequence.
- rst pulled low during LOAD → mem_we drops to 0 asynchronously and all outputs read 0. After release, run → full clean pass; L=40 with MAX_WORDS=16 → exactly 16 writes.
